// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: time-multiplexes a shared segment bus across NDIG digits,
// with a blanking gap per slot, a brightness on-window, and frame-atomic pattern commits.
module seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 20000,
  parameter int BLANK    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [2:0]      wr_addr,
  input  logic [6:0]      wr_data,
  input  logic            commit,
  input  logic [2:0]      bright,
  output logic [6:0]      segment,
  output logic [NDIG-1:0] digit_en,
  output logic            frame_start,
  output logic            commit_pend,
  output logic            commit_ack
);

  localparam int STEP  = (TICK_DIV - BLANK) / 8;
  localparam int CBITS = $clog2(TICK_DIV);
  localparam int DBITS = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CBITS-1:0] CNT_LAST = CBITS'(TICK_DIV - 1);
  localparam logic [DBITS-1:0] DIG_LAST = DBITS'(NDIG - 1);
  localparam logic [NDIG-1:0]  DIG_ONE  = {{(NDIG-1){1'b0}}, 1'b1};

  logic [CBITS-1:0] cnt_reg;
  logic [DBITS-1:0] d_reg;
  logic [2:0]       bright_q_reg;
  logic             pending_reg;
  logic [6:0]       shadow_reg [NDIG];
  logic [6:0]       active_reg [NDIG];

  logic [6:0]       segment_reg;
  logic [NDIG-1:0]  digit_en_reg;
  logic             frame_start_reg;
  logic             commit_ack_reg;

  logic             slot_end;
  logic             boundary;
  logic             apply;
  logic [31:0]      cnt_ext;
  logic [31:0]      win_end;
  logic [6:0]       segment_next;
  logic [NDIG-1:0]  digit_en_next;

  assign slot_end = (cnt_reg == CNT_LAST);
  assign boundary = slot_end && (d_reg == DIG_LAST);
  assign apply    = boundary && pending_reg;
  assign cnt_ext  = 32'(cnt_reg);
  assign win_end  = 32'(BLANK) + (32'(bright_q_reg) + 32'd1) * 32'(STEP);

  // Blank gap first, then the digit is enabled; segments only drive inside the on-window.
  always_comb begin
    segment_next  = '0;
    digit_en_next = '0;
    if (cnt_ext >= 32'(BLANK)) begin
      digit_en_next = DIG_ONE << d_reg;
      if (cnt_ext < win_end) begin
        segment_next = active_reg[d_reg];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      d_reg           <= '0;
      bright_q_reg    <= '0;
      pending_reg     <= 1'b0;
      segment_reg     <= '0;
      digit_en_reg    <= '0;
      frame_start_reg <= 1'b0;
      commit_ack_reg  <= 1'b0;
    end else begin
      cnt_reg <= slot_end ? '0 : cnt_reg + CBITS'(1);
      if (slot_end) begin
        d_reg <= (d_reg == DIG_LAST) ? '0 : d_reg + DBITS'(1);
      end
      if (cnt_reg == '0) begin
        bright_q_reg <= bright;
      end
      // A commit arriving on the boundary itself survives the copy and waits a frame.
      pending_reg     <= commit | (pending_reg & ~apply);
      segment_reg     <= segment_next;
      digit_en_reg    <= digit_en_next;
      frame_start_reg <= (cnt_reg == '0) && (d_reg == '0);
      commit_ack_reg  <= apply;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg[gi] <= '0;
          active_reg[gi] <= '0;
        end else begin
          if (apply) begin
            active_reg[gi] <= shadow_reg[gi];
          end
          if (wr_en && (wr_addr == 3'(gi))) begin
            shadow_reg[gi] <= wr_data;
          end
        end
      end
    end
  endgenerate

  assign segment     = segment_reg;
  assign digit_en    = digit_en_reg;
  assign frame_start = frame_start_reg;
  assign commit_pend = pending_reg;
  assign commit_ack  = commit_ack_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: per-cycle scoreboard of expected outputs plus scenario-level checks.
module tb_seg_scan_ctrl;

  localparam int ND   = 4;
  localparam int TD   = 40;
  localparam int BL   = 8;
  localparam int STEP = 4;
  localparam int FR   = ND * TD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [6:0]    wr_data = '0;
  logic          commit = 1'b0;
  logic [2:0]    bright = '0;
  logic [6:0]    segment;
  logic [ND-1:0] digit_en;
  logic          frame_start;
  logic          commit_pend;
  logic          commit_ack;

  seg_scan_ctrl #(.NDIG(ND), .TICK_DIV(TD), .BLANK(BL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .bright      (bright),
    .segment     (segment),
    .digit_en    (digit_en),
    .frame_start (frame_start),
    .commit_pend (commit_pend),
    .commit_ack  (commit_ack)
  );

  always #5 clk = ~clk;

  int          k;
  int          vecs;
  int          miss;
  logic [13:0] sb[$];
  logic [13:0] obs;
  logic [13:0] want;
  logic [6:0]  m_shadow [ND];
  logic [6:0]  m_act [ND];
  logic [2:0]  m_bq;
  logic        m_pend;

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_shadow[i] = '0;
      m_act[i]    = '0;
    end
    m_bq   = '0;
    m_pend = 1'b0;
    k      = 0;
    sb.delete();
  endtask

  // Expected outputs after the coming edge, from the cycle index since reset release.
  task automatic sb_push();
    int            cn;
    int            dd;
    logic [6:0]    seg;
    logic [ND-1:0] den;
    logic          apply;
    cn  = k % TD;
    dd  = (k / TD) % ND;
    seg = '0;
    den = '0;
    if (cn >= BL) begin
      den[dd] = 1'b1;
      if (cn < BL + (int'(m_bq) + 1) * STEP) seg = m_act[dd];
    end
    apply = (cn == TD - 1) && (dd == ND - 1) && m_pend;
    if (apply) m_act = m_shadow;
    if (wr_en && (int'(wr_addr) < ND)) m_shadow[wr_addr] = wr_data;
    m_pend = commit || (m_pend && !apply);
    if (cn == 0) m_bq = bright;
    sb.push_back({seg, den, (k % FR) == 0, m_pend, apply});
  endtask

  task automatic test_reset();
    int fs_cnt = 0;
    int seg_nz = 0;
    int multi  = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      obs = {segment, digit_en, frame_start, commit_pend, commit_ack};
      vecs++;
      if (obs !== 14'h0) begin
        miss++;
        $display("FAIL reset_hold got=%h want=%h", obs, 14'h0);
      end
    end
    rst_n  = 1'b1;
    bright = 3'd7;
    model_reset();
    for (int i = 0; i < 2 * FR; i++) begin
      sb_push();
      @(posedge clk); #1;
      k++;
      obs  = {segment, digit_en, frame_start, commit_pend, commit_ack};
      want = sb.pop_front();
      vecs++;
      if (obs !== want) begin
        miss++;
        $display("FAIL reset_scan k=%0d got=%h want=%h", k, obs, want);
      end
      if (k == 1) begin
        vecs++;
        if (frame_start !== 1'b1 || digit_en !== '0) begin
          miss++;
          $display("FAIL first_edge fs=%b den=%b want fs=1 den=0", frame_start, digit_en);
        end
      end
      if (frame_start) fs_cnt++;
      if (segment != 0) seg_nz++;
      if ($countones(digit_en) > 1) multi++;
    end
    vecs++;
    if (fs_cnt != 2 || seg_nz != 0 || multi != 0) begin
      miss++;
      $display("FAIL scan_summary frames=%0d seg_on=%0d multi=%0d want 2/0/0", fs_cnt, seg_nz, multi);
    end
    $display("reset_scan: %0d cycles, %0d frame_start pulses", 2 * FR, fs_cnt);
  endtask

  task automatic test_write_commit();
    logic [6:0] pat [ND];
    logic [6:0] seen [ND];
    int         acks  = 0;
    int         early = 0;
    bit         acked = 0;
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    for (int b = 0; b < ND; b++) seen[b] = '0;
    for (int i = 0; i < 340; i++) begin
      wr_en  = 1'b0;
      commit = 1'b0;
      if (i >= 10 && i < 14) begin
        wr_en   = 1'b1;
        wr_addr = 3'(i - 10);
        wr_data = pat[i - 10];
      end
      if (i == 50) commit = 1'b1;
      sb_push();
      @(posedge clk); #1;
      k++;
      obs  = {segment, digit_en, frame_start, commit_pend, commit_ack};
      want = sb.pop_front();
      vecs++;
      if (obs !== want) begin
        miss++;
        $display("FAIL wr_commit k=%0d got=%h want=%h", k, obs, want);
      end
      if (i == 50) begin
        vecs++;
        if (commit_pend !== 1'b1) begin
          miss++;
          $display("FAIL pend_rise got=%b want=1", commit_pend);
        end
      end
      if (commit_ack) begin
        acks++;
        acked = 1;
      end else if (!acked && segment != 0) begin
        early++;
      end
      if (acked) begin
        for (int b = 0; b < ND; b++) if (digit_en[b] && segment != 0) seen[b] = segment;
      end
    end
    wr_en  = 1'b0;
    commit = 1'b0;
    vecs++;
    if (acks != 1 || early != 0) begin
      miss++;
      $display("FAIL commit_ack acks=%0d early_seg=%0d want 1/0", acks, early);
    end
    for (int b = 0; b < ND; b++) begin
      vecs++;
      if (seen[b] !== pat[b]) begin
        miss++;
        $display("FAIL pattern_d%0d got=%h want=%h", b, seen[b], pat[b]);
      end
    end
    $display("write_commit: %0d ack(s), digit0=%h digit3=%h", acks, seen[0], seen[3]);
  endtask

  task automatic test_brightness();
    logic [2:0] bset [4];
    int         exp_on [4];
    int         on_cnt;
    bset   = '{3'd0, 3'd3, 3'd3, 3'd0};
    exp_on = '{4, 16, 16, 4};
    for (int p = 0; p < 4; p++) begin
      if (p != 3) bright = bset[p];
      while (k % TD != 0) begin
        sb_push();
        @(posedge clk); #1;
        k++;
        obs  = {segment, digit_en, frame_start, commit_pend, commit_ack};
        want = sb.pop_front();
        vecs++;
        if (obs !== want) begin
          miss++;
          $display("FAIL bright_align k=%0d got=%h want=%h", k, obs, want);
        end
      end
      on_cnt = 0;
      for (int c = 0; c < TD; c++) begin
        if (p == 2 && c == 20) bright = 3'd0;
        sb_push();
        @(posedge clk); #1;
        k++;
        obs  = {segment, digit_en, frame_start, commit_pend, commit_ack};
        want = sb.pop_front();
        vecs++;
        if (obs !== want) begin
          miss++;
          $display("FAIL bright_slot k=%0d got=%h want=%h", k, obs, want);
        end
        if (segment != 0) on_cnt++;
      end
      vecs++;
      if (on_cnt != exp_on[p]) begin
        miss++;
        $display("FAIL bright_window phase=%0d on=%0d want=%0d", p, on_cnt, exp_on[p]);
      end
      $display("brightness phase %0d: %0d on-cycles", p, on_cnt);
    end
    bright = 3'd7;
  endtask

  task automatic test_boundary();
    logic [6:0] seen [ND];
    logic [6:0] exp_post [ND];
    logic [6:0] pre0   = '0;
    int         acks   = 0;
    int         ack_at = -1;
    int         n      = 0;
    exp_post = '{7'h77, 7'h06, 7'h5B, 7'h4F};
    for (int b = 0; b < ND; b++) seen[b] = '0;
    while ((k % FR != FR - 1) && (n < 2 * FR)) begin
      wr_en   = (n == 3);
      wr_addr = 3'd5;
      wr_data = 7'h7F;
      sb_push();
      @(posedge clk); #1;
      k++;
      n++;
      obs  = {segment, digit_en, frame_start, commit_pend, commit_ack};
      want = sb.pop_front();
      vecs++;
      if (obs !== want) begin
        miss++;
        $display("FAIL bnd_align k=%0d got=%h want=%h", k, obs, want);
      end
    end
    vecs++;
    if (k % FR != FR - 1) begin
      miss++;
      $display("FAIL bnd_timeout k=%0d want boundary", k);
    end
    for (int i = -1; i < 2 * FR + 5; i++) begin
      wr_en  = (i == -1);
      commit = (i == -1);
      if (i == -1) begin
        wr_addr = 3'd0;
        wr_data = 7'h77;
      end
      sb_push();
      @(posedge clk); #1;
      k++;
      obs  = {segment, digit_en, frame_start, commit_pend, commit_ack};
      want = sb.pop_front();
      vecs++;
      if (obs !== want) begin
        miss++;
        $display("FAIL boundary k=%0d got=%h want=%h", k, obs, want);
      end
      if (commit_ack) begin
        acks++;
        ack_at = i;
      end
      if (ack_at < 0 && digit_en[0] && segment != 0) pre0 = segment;
      if (ack_at >= 0) begin
        for (int b = 0; b < ND; b++) if (digit_en[b] && segment != 0) seen[b] = segment;
      end
    end
    wr_en  = 1'b0;
    commit = 1'b0;
    vecs++;
    if (acks != 1 || ack_at != FR - 1) begin
      miss++;
      $display("FAIL bnd_ack acks=%0d at=%0d want 1 at %0d", acks, ack_at, FR - 1);
    end
    vecs++;
    if (pre0 !== 7'h3F) begin
      miss++;
      $display("FAIL bnd_not_early got=%h want=%h", pre0, 7'h3F);
    end
    for (int b = 0; b < ND; b++) begin
      vecs++;
      if (seen[b] !== exp_post[b]) begin
        miss++;
        $display("FAIL bnd_pattern_d%0d got=%h want=%h", b, seen[b], exp_post[b]);
      end
    end
    $display("boundary: ack %0d cycles after boundary commit, digit0=%h digit1=%h", ack_at + 1, seen[0], seen[1]);
  endtask

  task automatic test_async_reset();
    int acks   = 0;
    int seg_nz = 0;
    for (int i = 0; i < FR + 20; i++) begin
      commit = (i == 5);
      sb_push();
      @(posedge clk); #1;
      k++;
      obs  = {segment, digit_en, frame_start, commit_pend, commit_ack};
      want = sb.pop_front();
      vecs++;
      if (obs !== want) begin
        miss++;
        $display("FAIL pre_areset k=%0d got=%h want=%h", k, obs, want);
      end
      if (commit_pend && (k % FR) > 20 && (k % FR) < FR - 20 && i > 10) break;
    end
    commit = 1'b0;
    vecs++;
    if (commit_pend !== 1'b1 || digit_en == '0) begin
      miss++;
      $display("FAIL areset_setup pend=%b den=%b want pend=1 den!=0", commit_pend, digit_en);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {segment, digit_en, frame_start, commit_pend, commit_ack};
    vecs++;
    if (obs !== 14'h0) begin
      miss++;
      $display("FAIL areset_immediate got=%h want=%h", obs, 14'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FR; i++) begin
      sb_push();
      @(posedge clk); #1;
      k++;
      obs  = {segment, digit_en, frame_start, commit_pend, commit_ack};
      want = sb.pop_front();
      vecs++;
      if (obs !== want) begin
        miss++;
        $display("FAIL post_areset k=%0d got=%h want=%h", k, obs, want);
      end
      if (commit_ack) acks++;
      if (segment != 0) seg_nz++;
    end
    vecs++;
    if (acks != 0 || seg_nz != 0) begin
      miss++;
      $display("FAIL areset_lost acks=%0d seg_on=%0d want 0/0", acks, seg_nz);
    end
    $display("async_reset: %0d acks, %0d lit cycles after release", acks, seg_nz);
  endtask

  initial begin
    vecs = 0;
    miss = 0;
    model_reset();
    test_reset();
    test_write_commit();
    test_brightness();
    test_boundary();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
